// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 block.
//   - CP0 register indices used by mfc0/mtc0
//   - exception codes written into Cause.ExcCode
//   - exception handler entry PC, imported by the fetch stage
//   - PRId default value
package cp0_pkg;

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ADDR     = 32'h0000_4180;
  localparam logic [31:0] PRID_VAL_DEFAULT = 32'h2333_0913;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer for CP0 (built only with CP0_TIMER_EN).
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_wr_count           load Count from i_wdata
//   i_wr_compare         load Compare from i_wdata, clears TI
//   i_wdata              mtc0 write data
//   o_count, o_compare   current register values
//   o_ti                 sticky timer interrupt flag
module cp0_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_count,
  input  logic        i_wr_compare,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= i_wr_count ? i_wdata : r_count + 32'd1;
      if (i_wr_compare) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 for the M stage of the 5-stage MIPS pipeline.
// Holds SR/Cause/EPC, arbitrates interrupts against in-pipe exceptions and
// raises Req to flush the pipe. Optional Count/Compare timer under the
// CP0_TIMER_EN macro.
// Ports:
//   clk, reset  clock, synchronous active-low reset
//   en          mtc0 write enable
//   CP0Addr     register index for mfc0/mtc0
//   CP0In       mtc0 write data
//   CP0Out      mfc0 read data (combinational)
//   VPC, BDIn   PC and delay-slot flag of the M-stage instruction
//   ExcCodeIn   pending exception code (0 = none)
//   HWInt       external interrupt lines [7:2]
//   EXLClr      eret in M stage
//   EPCOut      current EPC
//   Req         take exception/interrupt this cycle
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = PRID_VAL_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic [5:0]  w_int_lines;
  logic [5:0]  w_ip_rd;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr;
  logic [31:0] w_epc_next;
  logic [31:0] w_rdata;

  // mtc0 is dropped whenever an exception is taken in the same cycle
  assign w_wr = en & ~w_req;

`ifdef CP0_TIMER_EN
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;

  cp0_timer u_timer (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_wr_count   (w_wr && (CP0Addr == ADDR_COUNT)),
    .i_wr_compare (w_wr && (CP0Addr == ADDR_COMPARE)),
    .i_wdata      (CP0In),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  // Timer flag replaces external line 5 (IP[7]) for both request and readback
  assign w_int_lines = {w_ti, HWInt[4:0]};
  assign w_ip_rd     = {w_ti, r_ip[4:0]};
`else
  assign w_int_lines = HWInt;
  assign w_ip_rd     = r_ip;
`endif

  assign w_int_req  = r_ie & ~r_exl & (|(w_int_lines & r_im));
  assign w_exc_req  = ~r_exl & (ExcCodeIn != 5'd0);
  assign w_req      = w_int_req | w_exc_req;
  assign w_epc_next = word_align(BDIn ? (VPC - 32'd4) : VPC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? EXC_INT : ExcCodeIn;
        r_bd      <= BDIn;
        r_epc     <= w_epc_next;
      end else begin
        if (w_wr && (CP0Addr == ADDR_SR)) begin
          r_im  <= CP0In[15:10];
          r_exl <= CP0In[1];
          r_ie  <= CP0In[0];
        end
        if (w_wr && (CP0Addr == ADDR_EPC)) begin
          r_epc <= word_align(CP0In);
        end
        // Placed after the SR write so eret wins the EXL bit
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (CP0Addr)
      ADDR_SR:      w_rdata = {16'b0, r_im, 8'b0, r_exl, r_ie};
      ADDR_CAUSE:   w_rdata = {r_bd, 15'b0, w_ip_rd, 3'b0, r_exccode, 2'b0};
      ADDR_EPC:     w_rdata = r_epc;
      ADDR_PRID:    w_rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   w_rdata = w_count;
      ADDR_COMPARE: w_rdata = w_compare;
`endif
      default:      w_rdata = '0;
    endcase
  end

  assign CP0Out = w_rdata;
  assign EPCOut = r_epc;
  assign Req    = w_req;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cp0_unit #(.PRID_VAL(32'h2333_0913)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Addr   (CP0Addr),
    .CP0In     (CP0In),
    .CP0Out    (CP0Out),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; CP0Addr = a; CP0In = d;
    tick();
    en = 1'b0; CP0In = '0;
  endtask

  task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
    CP0Addr = a;
    #1;
    d = CP0Out;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0; tick(); tick();
    reset = 1'b1;
    mtc0(5'd12, 32'h0000_FC03);
    mtc0(5'd14, 32'h0000_1234);
    HWInt = 6'h3F; tick();
    HWInt = 6'h00;
    reset = 1'b0; tick(); tick();
    reset = 1'b1;
    mfc0(5'd12, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_sr: got %h expected %h", v, 32'h0); end
    mfc0(5'd13, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_cause: got %h expected %h", v, 32'h0); end
    mfc0(5'd14, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected %h", v, 32'h0); end
    n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", Req); end
    n_checks++; if (EPCOut !== 32'h0) begin n_fail++; $display("FAIL reset_epcout: got %h expected %h", EPCOut, 32'h0); end
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_0401);
    mfc0(5'd12, v);
    n_checks++; if (v !== 32'h0000_0401) begin n_fail++; $display("FAIL int_sr_write: got %h expected %h", v, 32'h0000_0401); end
    HWInt = 6'b000001; VPC = 32'h0000_3010; BDIn = 1'b0;
    #1;
    n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL int_req: got %b expected 1", Req); end
    tick();
    n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL int_req_masked: got %b expected 0", Req); end
    mfc0(5'd14, v);
    n_checks++; if (v !== 32'h0000_3010) begin n_fail++; $display("FAIL int_epc: got %h expected %h", v, 32'h0000_3010); end
    mfc0(5'd13, v);
    n_checks++; if (v !== 32'h0000_0400) begin n_fail++; $display("FAIL int_cause: got %h expected %h", v, 32'h0000_0400); end
    mfc0(5'd12, v);
    n_checks++; if (v !== 32'h0000_0403) begin n_fail++; $display("FAIL int_sr_exl: got %h expected %h", v, 32'h0000_0403); end
    HWInt = 6'b0;
  endtask

  task automatic test_delay_slot();
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_0000);
    ExcCodeIn = 5'd12; VPC = 32'h0000_3024; BDIn = 1'b1;
    #1;
    n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL ds_req: got %b expected 1", Req); end
    tick();
    n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL ds_nested_lost: got %b expected 0", Req); end
    mfc0(5'd14, v);
    n_checks++; if (v !== 32'h0000_3020) begin n_fail++; $display("FAIL ds_epc: got %h expected %h", v, 32'h0000_3020); end
    mfc0(5'd13, v);
    n_checks++; if (v !== 32'h8000_0030) begin n_fail++; $display("FAIL ds_cause: got %h expected %h", v, 32'h8000_0030); end
    ExcCodeIn = 5'd0; BDIn = 1'b0;
  endtask

  task automatic test_priority();
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h0000_500B; BDIn = 1'b0;
    en = 1'b1; CP0Addr = 5'd14; CP0In = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %b expected 1", Req); end
    tick();
    en = 1'b0; CP0In = '0; ExcCodeIn = 5'd0;
    mfc0(5'd14, v);
    n_checks++; if (v !== 32'h0000_5008) begin n_fail++; $display("FAIL prio_epc: got %h expected %h", v, 32'h0000_5008); end
    n_checks++; if (EPCOut !== 32'h0000_5008) begin n_fail++; $display("FAIL prio_epcout: got %h expected %h", EPCOut, 32'h0000_5008); end
    mfc0(5'd13, v);
    n_checks++; if (v !== 32'h0000_0400) begin n_fail++; $display("FAIL prio_cause: got %h expected %h", v, 32'h0000_0400); end
  endtask

  task automatic test_eret();
    logic [31:0] v;
    EXLClr = 1'b1; en = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_FC03;
    #1;
    n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL eret_req_masked: got %b expected 0", Req); end
    tick();
    EXLClr = 1'b0; en = 1'b0; CP0In = '0;
    mfc0(5'd12, v);
    n_checks++; if (v !== 32'h0000_FC01) begin n_fail++; $display("FAIL eret_sr: got %h expected %h", v, 32'h0000_FC01); end
    n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL eret_rearm_req: got %b expected 1", Req); end
    HWInt = 6'b0;
    #1;
    n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL eret_req_drop: got %b expected 0", Req); end
    tick();
  endtask

  task automatic test_mtc0();
    logic [31:0] v;
    en = 1'b1; CP0Addr = 5'd14; CP0In = 32'h0000_ABCF;
    #1;
    n_checks++; if (CP0Out !== 32'h0000_5008) begin n_fail++; $display("FAIL mtc0_no_forward: got %h expected %h", CP0Out, 32'h0000_5008); end
    tick();
    en = 1'b0; CP0In = '0;
    mfc0(5'd14, v);
    n_checks++; if (v !== 32'h0000_ABCC) begin n_fail++; $display("FAIL mtc0_epc: got %h expected %h", v, 32'h0000_ABCC); end
    n_checks++; if (EPCOut !== 32'h0000_ABCC) begin n_fail++; $display("FAIL mtc0_epcout: got %h expected %h", EPCOut, 32'h0000_ABCC); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    mfc0(5'd13, v);
    n_checks++; if (v !== 32'h0000_0000) begin n_fail++; $display("FAIL mtc0_cause_ro: got %h expected %h", v, 32'h0); end
    mfc0(5'd15, v);
    n_checks++; if (v !== 32'h2333_0913) begin n_fail++; $display("FAIL prid: got %h expected %h", v, 32'h2333_0913); end
    mfc0(5'd0, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL addr0_read: got %h expected %h", v, 32'h0); end
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'h0000_0055);
    mtc0(5'd11, 32'h0000_0066);
    mfc0(5'd9, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL count_absent: got %h expected %h", v, 32'h0); end
    mfc0(5'd11, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL compare_absent: got %h expected %h", v, 32'h0); end
`endif
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    logic [31:0] v;
    bit found;
    HWInt = 6'b0;
    reset = 1'b0; tick();
    reset = 1'b1;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      mfc0(5'd9, v);
      if (v == 32'd5) found = 1'b1;
      else begin
        n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL timer_early_req: got %b expected 0 (count %0d)", Req, v); end
        tick();
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL timer_reach5: got count %0d expected 5 within bound", v); end
    n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL timer_req_at5: got %b expected 0", Req); end
    tick();
    n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL timer_req: got %b expected 1", Req); end
    tick();
    mfc0(5'd13, v);
    n_checks++; if (v[15] !== 1'b1) begin n_fail++; $display("FAIL timer_ip7_set: got %b expected 1", v[15]); end
    mtc0(5'd11, 32'd100);
    mfc0(5'd13, v);
    n_checks++; if (v[15] !== 1'b0) begin n_fail++; $display("FAIL timer_ip7_clr: got %b expected 0", v[15]); end
  endtask
`endif

  initial begin
    reset = 1'b0; en = 1'b0; CP0Addr = '0; CP0In = '0; VPC = '0;
    BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    test_reset();
    test_interrupt();
    test_delay_slot();
    test_priority();
    test_eret();
    test_mtc0();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
